// File: rtl/glm_write_arbiter_if.sv
// Requester and DMA write-channel bundle for glm_write_arbiter.
// slave: the arbiter side; master: requesters plus DMA channel model.
interface glm_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 42,
  parameter int DATA_W  = 512
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*32-1:0]     req_len;
  logic [NUM_REQ-1:0]        req_fence;
  logic [NUM_REQ-1:0]        req_grant;
  logic [NUM_REQ-1:0]        req_done;
  logic [NUM_REQ-1:0]        wr_valid;
  logic [NUM_REQ*DATA_W-1:0] wr_data;
  logic [NUM_REQ-1:0]        wr_almostfull;
  logic                      dma_idle;
  logic                      dma_active;
  logic                      dma_walmostfull;
  logic                      dma_wack;
  logic                      dma_start;
  logic [ADDR_W-1:0]         dma_addr;
  logic [31:0]               dma_len;
  logic                      dma_we;
  logic [DATA_W-1:0]         dma_wdata;
  logic [2:0]                owner;
  logic                      busy;
  logic                      overrun;

  modport slave (
    input  req_valid, req_addr, req_len, req_fence,
    input  wr_valid, wr_data,
    input  dma_idle, dma_active, dma_walmostfull, dma_wack,
    output req_grant, req_done, wr_almostfull,
    output dma_start, dma_addr, dma_len, dma_we, dma_wdata,
    output owner, busy, overrun
  );

  modport master (
    output req_valid, req_addr, req_len, req_fence,
    output wr_valid, wr_data,
    output dma_idle, dma_active, dma_walmostfull, dma_wack,
    input  req_grant, req_done, wr_almostfull,
    input  dma_start, dma_addr, dma_len, dma_we, dma_wdata,
    input  owner, busy, overrun
  );
endinterface

// File: rtl/glm_write_arbiter.sv
// Round-robin sharing of one DMA write channel among NUM_REQ requesters.
// Optional GLM_WRARB_TIMEOUT_EN adds a STREAM watchdog and timeout port.
module glm_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 42,
  parameter int DATA_W  = 512
) (
  input  logic clk,
  input  logic reset,
`ifdef GLM_WRARB_TIMEOUT_EN
  output logic timeout,
`endif
  glm_write_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, START, STREAM, DONE
  } state_t;

  state_t state, state_d;

  logic [2:0]         rr_ptr, own;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        len_q, sent, acks;
  logic               fence_q;

  logic               hi_f, lo_f, found;
  logic [2:0]         hi_w, lo_w, win;
  logic [ADDR_W-1:0]  win_addr;
  logic [31:0]        win_len;
  logic               win_fence;
  logic [NUM_REQ-1:0] win_oh, own_oh;
  logic               own_valid;
  logic [DATA_W-1:0]  own_data;
  logic               do_wr, do_ack, over_hit, wd_fire;

  // lowest request at or above rr_ptr wins, else lowest below it
  always_comb begin
    hi_f = 1'b0;
    lo_f = 1'b0;
    hi_w = '0;
    lo_w = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        if (3'(i) >= rr_ptr) begin
          hi_f = 1'b1;
          hi_w = 3'(i);
        end else begin
          lo_f = 1'b1;
          lo_w = 3'(i);
        end
      end
    end
    found = hi_f | lo_f;
    win   = hi_f ? hi_w : lo_w;
  end

  always_comb begin
    win_addr  = '0;
    win_len   = '0;
    win_fence = 1'b0;
    win_oh    = '0;
    own_valid = 1'b0;
    own_data  = '0;
    own_oh    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == 3'(i)) begin
        win_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        win_len   = bus.req_len[i*32 +: 32];
        win_fence = bus.req_fence[i];
        win_oh[i] = 1'b1;
      end
      if (own == 3'(i)) begin
        own_valid = bus.wr_valid[i];
        own_data  = bus.wr_data[i*DATA_W +: DATA_W];
        own_oh[i] = 1'b1;
      end
    end
  end

`ifdef GLM_WRARB_TIMEOUT_EN
  logic [19:0] wd;
  assign wd_fire = (state == STREAM) && (wd == '1);
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    state_d  = state;
    do_wr    = 1'b0;
    do_ack   = 1'b0;
    over_hit = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) state_d = (win_len == '0) ? DONE : START;
      end
      START: begin
        if (bus.dma_idle) state_d = STREAM;
      end
      STREAM: begin
        do_wr    = own_valid & bus.dma_active & (sent < len_q);
        over_hit = own_valid & (sent == len_q);
        do_ack   = bus.dma_wack;
        if (!fence_q && do_wr && (sent + 32'd1 == len_q))
          state_d = DONE;
        if (fence_q && do_ack && (acks + 32'd1 == len_q))
          state_d = DONE;
        if (wd_fire) state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr            <= '0;
      own               <= '0;
      addr_q            <= '0;
      len_q             <= '0;
      fence_q           <= 1'b0;
      sent              <= '0;
      acks              <= '0;
      bus.req_grant     <= '0;
      bus.req_done      <= '0;
      bus.wr_almostfull <= '1;
      bus.dma_start     <= 1'b0;
      bus.dma_addr      <= '0;
      bus.dma_len       <= '0;
      bus.dma_we        <= 1'b0;
      bus.dma_wdata     <= '0;
      bus.busy          <= 1'b0;
      bus.overrun       <= 1'b0;
    end else begin
      bus.req_grant     <= '0;
      bus.req_done      <= '0;
      bus.dma_start     <= 1'b0;
      bus.dma_we        <= 1'b0;
      bus.wr_almostfull <= '1;
      unique case (state)
        IDLE: begin
          if (found) begin
            bus.req_grant <= win_oh;
            bus.busy      <= 1'b1;
            own           <= win;
            addr_q        <= win_addr;
            len_q         <= win_len;
            fence_q       <= win_fence;
          end
        end
        START: begin
          if (bus.dma_idle) begin
            bus.dma_start <= 1'b1;
            bus.dma_addr  <= addr_q;
            bus.dma_len   <= len_q;
            sent          <= '0;
            acks          <= '0;
          end
        end
        STREAM: begin
          bus.wr_almostfull <= ~own_oh |
            {NUM_REQ{bus.dma_walmostfull | ~bus.dma_active}};
          if (do_wr) begin
            bus.dma_we    <= 1'b1;
            bus.dma_wdata <= own_data;
            sent          <= sent + 32'd1;
          end
          if (do_ack)   acks        <= acks + 32'd1;
          if (over_hit) bus.overrun <= 1'b1;
        end
        DONE: begin
          bus.req_done <= own_oh;
          bus.busy     <= 1'b0;
          rr_ptr <= (own == 3'(NUM_REQ - 1)) ? 3'd0 : own + 3'd1;
        end
      endcase
    end
  end

  assign bus.owner = own;

`ifdef GLM_WRARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd      <= '0;
      timeout <= 1'b0;
    end else begin
      if (state != STREAM || do_wr || do_ack) wd <= '0;
      else                                    wd <= wd + 20'd1;
      if (wd_fire) timeout <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_glm_write_arbiter.sv
// Bench for glm_write_arbiter: requester/DMA model with scoreboard
// queues, a vector table and hand-written multi-cycle sequences.
module tb_glm_write_arbiter;
  localparam int N  = 4;
  localparam int AW = 42;
  localparam int DW = 512;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  glm_write_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  glm_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int          idx;
    int          len;
    bit          fence;
    logic [AW-1:0] addr;
    int          extra;
    int          exp_we;
    bit          exp_ovr;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   len;
  } start_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int we_cnt = 0, done_cnt = 0;
  int last_we_cyc = 0, done_cyc = 0, grant_cyc = 0, ack_cyc = 0;
  int ack_req = 0, ack_sent = 0;
  int req_cnt[N], served[N], send_rem[N], seq[N];
  int len_cfg[N], extra_cfg[N], rise_cyc[N];
  bit fence_cfg[N];
  logic [AW-1:0] addr_cfg[N];
  logic [N-1:0] nonown = '0;

  int            exp_g[$];
  int            exp_d[$];
  start_t        exp_s[$];
  logic [DW-1:0] exp_w[$];

  function automatic logic [DW-1:0] pat(int i, int k);
    return {16{i[7:0], k[23:0]}};
  endfunction

  task automatic chk(string nm, logic [DW-1:0] act,
                     logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_we(int target, int lim);
    int n = 0;
    while (we_cnt < target && n < lim) begin
      @(posedge clk); #2; n++;
    end
    chk("we_reached", we_cnt, target);
  endtask

  task automatic wait_done(int target, int lim);
    int n = 0;
    while (done_cnt < target && n < lim) begin
      @(posedge clk); #2; n++;
    end
    chk("done_reached", done_cnt, target);
  endtask

  function automatic int sb_left();
    return exp_g.size() + exp_d.size() + exp_s.size() + exp_w.size();
  endfunction

  // requesters + DMA channel + output monitor, one process
  task automatic model();
    int g;
    start_t s;
    logic nv;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (reset) begin
        exp_g.delete(); exp_d.delete();
        exp_s.delete(); exp_w.delete();
        for (int i = 0; i < N; i++) begin
          send_rem[i] = 0;
          served[i]   = req_cnt[i];
        end
        ack_sent      = ack_req;
        bus.req_valid = '0;
        bus.wr_valid  = '0;
        bus.dma_wack  = 1'b0;
        continue;
      end
      if (bus.req_grant != '0) begin
        g = 0;
        for (int i = N - 1; i >= 0; i--)
          if (bus.req_grant[i]) g = i;
        if (exp_g.size() == 0)
          chk("grant_unexpected", bus.req_grant, 0);
        else
          chk("grant_order", bus.req_grant,
              N'(1) << exp_g.pop_front());
        grant_cyc   = cyc;
        served[g]   = served[g] + 1;
        send_rem[g] = len_cfg[g] + extra_cfg[g];
        seq[g]      = 0;
        if (len_cfg[g] != 0) begin
          s.addr = addr_cfg[g];
          s.len  = 32'(len_cfg[g]);
          exp_s.push_back(s);
        end
        exp_d.push_back(g);
      end
      if (bus.dma_start) begin
        if (exp_s.size() == 0)
          chk("start_unexpected", bus.dma_start, 0);
        else begin
          s = exp_s.pop_front();
          chk("start_addr", bus.dma_addr, s.addr);
          chk("start_len", bus.dma_len, s.len);
        end
      end
      if (bus.dma_we) begin
        we_cnt++;
        last_we_cyc = cyc;
        if (exp_w.size() == 0)
          chk("we_unexpected", bus.dma_we, 0);
        else
          chk("we_data", bus.dma_wdata, exp_w.pop_front());
      end
      if (bus.req_done != '0) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_d.size() == 0)
          chk("done_unexpected", bus.req_done, 0);
        else
          chk("done_owner", bus.req_done,
              N'(1) << exp_d.pop_front());
      end
      bus.wr_valid = nonown;
      for (int i = 0; i < N; i++) begin
        bus.req_addr[i*AW +: AW] = addr_cfg[i];
        bus.req_len[i*32 +: 32]  = 32'(len_cfg[i]);
        bus.req_fence[i]         = fence_cfg[i];
        if (send_rem[i] > 0 && !bus.wr_almostfull[i]) begin
          bus.wr_valid[i]          = 1'b1;
          bus.wr_data[i*DW +: DW]  = pat(i, seq[i]);
          if (seq[i] < len_cfg[i]) exp_w.push_back(pat(i, seq[i]));
          seq[i]++;
          send_rem[i]--;
        end
        nv = (req_cnt[i] != served[i]);
        if (nv && !bus.req_valid[i]) rise_cyc[i] = cyc;
        bus.req_valid[i] = nv;
      end
      bus.dma_wack = (ack_sent < ack_req);
      if (bus.dma_wack) begin
        ack_sent++;
        ack_cyc = cyc;
      end
    end
  endtask

  task automatic set_cfg(int i, int len, bit fence,
                         logic [AW-1:0] addr, int extra);
    len_cfg[i]   = len;
    fence_cfg[i] = fence;
    addr_cfg[i]  = addr;
    extra_cfg[i] = extra;
  endtask

  initial begin
    vec_t vt[5];
    vec_t v;
    int   w0, d0;

    vt[0] = '{0, 4, 1'b0, 42'h100,         0, 4, 1'b0};
    vt[1] = '{2, 0, 1'b0, 42'h200,         0, 0, 1'b0};
    vt[2] = '{3, 1, 1'b1, 42'h3_0000_0000, 0, 1, 1'b0};
    vt[3] = '{1, 3, 1'b0, 42'h3FF_FFFF_FFC0, 0, 3, 1'b0};
    vt[4] = '{2, 4, 1'b1, 42'h440,         1, 4, 1'b1};

    for (int i = 0; i < N; i++) begin
      req_cnt[i] = 0; served[i] = 0; send_rem[i] = 0;
      seq[i] = 0; rise_cyc[i] = 0;
      set_cfg(i, 0, 1'b0, '0, 0);
    end
    bus.req_valid       = '0;
    bus.req_addr        = '0;
    bus.req_len         = '0;
    bus.req_fence       = '0;
    bus.wr_valid        = '0;
    bus.wr_data         = '0;
    bus.dma_idle        = 1'b1;
    bus.dma_active      = 1'b1;
    bus.dma_walmostfull = 1'b0;
    bus.dma_wack        = 1'b0;

    fork
      model();
    join_none

    cycles(2); #2;
    chk("rst_grant", bus.req_grant, 0);
    chk("rst_done", bus.req_done, 0);
    chk("rst_almostfull", bus.wr_almostfull, 4'hF);
    chk("rst_start", bus.dma_start, 0);
    chk("rst_we", bus.dma_we, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_overrun", bus.overrun, 0);
    @(negedge clk) reset = 1'b0;
    cycles(1); #2;

    for (int k = 0; k < 5; k++) begin
      v = vt[k];
      set_cfg(v.idx, v.len, v.fence, v.addr, v.extra);
      w0 = we_cnt;
      d0 = done_cnt;
      exp_g.push_back(v.idx);
      req_cnt[v.idx]++;
      if (v.fence) begin
        wait_we(w0 + v.exp_we, 100);
        cycles(4); #2;
        ack_req += v.len;
      end
      wait_done(d0 + 1, 200);
      chk("grant_latency", grant_cyc, rise_cyc[v.idx] + 1);
      if (v.len == 0)
        chk("len0_done_lat", done_cyc, grant_cyc + 1);
      else if (v.fence)
        chk("fence_done_lat", done_cyc, ack_cyc + 2);
      else
        chk("done_after_we", done_cyc, last_we_cyc + 1);
      chk("we_count", we_cnt - w0, v.exp_we);
      chk("overrun", bus.overrun, v.exp_ovr);
      chk("busy_after", bus.busy, 0);
      chk("sb_empty", sb_left(), 0);
    end

    // rr_ptr is 3 after owner 2: request 1 and 3 together
    set_cfg(1, 0, 1'b0, 42'h10, 0);
    set_cfg(3, 0, 1'b0, 42'h30, 0);
    d0 = done_cnt;
    exp_g.push_back(3);
    exp_g.push_back(1);
    req_cnt[1]++;
    req_cnt[3]++;
    wait_done(d0 + 2, 100);
    chk("rr_sb_empty", sb_left(), 0);

    // fenced: completion waits for delayed acks
    set_cfg(0, 3, 1'b1, 42'h5000, 0);
    w0 = we_cnt;
    d0 = done_cnt;
    exp_g.push_back(0);
    req_cnt[0]++;
    wait_we(w0 + 3, 100);
    cycles(10); #2;
    chk("fence_no_early_done", done_cnt - d0, 0);
    ack_req += 3;
    wait_done(d0 + 1, 100);
    chk("fence_done_cyc", done_cyc, ack_cyc + 2);

    // non-owner traffic must never reach the channel
    set_cfg(1, 4, 1'b0, 42'h6000, 0);
    w0 = we_cnt;
    d0 = done_cnt;
    nonown = 4'b1000;
    exp_g.push_back(1);
    req_cnt[1]++;
    wait_done(d0 + 1, 100);
    nonown = '0;
    chk("nonown_we_count", we_cnt - w0, 4);
    chk("nonown_sb_empty", sb_left(), 0);

    // reset in the middle of a stream
    set_cfg(2, 8, 1'b0, 42'h7000, 0);
    w0 = we_cnt;
    exp_g.push_back(2);
    req_cnt[2]++;
    wait_we(w0 + 2, 100);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_we", bus.dma_we, 0);
    chk("arst_almostfull", bus.wr_almostfull, 4'hF);
    chk("arst_owner", bus.owner, 0);
    chk("arst_overrun", bus.overrun, 0);
    chk("arst_done", bus.req_done, 0);
    cycles(2);
    @(negedge clk) reset = 1'b0;
    d0 = done_cnt;
    cycles(5); #2;
    chk("no_done_after_rst", done_cnt - d0, 0);
    set_cfg(1, 0, 1'b0, 42'h11, 0);
    set_cfg(3, 0, 1'b0, 42'h33, 0);
    exp_g.push_back(1);
    exp_g.push_back(3);
    req_cnt[1]++;
    req_cnt[3]++;
    wait_done(d0 + 2, 100);
    chk("post_rst_sb_empty", sb_left(), 0);

    // all four held: grants 0,1,2,3 then 0 again
    for (int i = 0; i < N; i++)
      set_cfg(i, 2, 1'b0, AW'(32'h10000 + i * 32'h1000), 0);
    w0 = we_cnt;
    d0 = done_cnt;
    exp_g.push_back(0);
    exp_g.push_back(1);
    exp_g.push_back(2);
    exp_g.push_back(3);
    exp_g.push_back(0);
    req_cnt[0] += 2;
    req_cnt[1]++;
    req_cnt[2]++;
    req_cnt[3]++;
    wait_done(d0 + 5, 400);
    chk("rr_we_count", we_cnt - w0, 10);
    cycles(3); #2;
    chk("final_sb_empty", sb_left(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/glm_write_arbiter.md
Name: glm_write_arbiter

Overview:
- Shares one DMA write channel among NUM_REQ writeback requesters, e.g. parallel writeback units in a multi-engine GLM build.
- Arbitrates round-robin and issues the DMA start for the winner.
- Muxes the winner's cache-line stream onto the channel and counts sent/acked lines.
- Releases the channel on completion, honouring a per-request write fence.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 42, cache-line address width (t_claddr)
DATA_W, 512, cache-line width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  requester i wants the channel; held until req_grant[i]
req_addr  in  NUM_REQ*ADDR_W  start line address per requester
req_len  in  NUM_REQ*32  line count per requester
req_fence  in  NUM_REQ  1: complete on ack count; 0: complete on sent count
req_grant  out  NUM_REQ  one-cycle one-hot accept pulse
req_done  out  NUM_REQ  one-cycle completion pulse to owner
wr_valid  in  NUM_REQ  line valid from requester i
wr_data  in  NUM_REQ*DATA_W  line data
wr_almostfull  out  NUM_REQ  backpressure to requester i
dma_idle  in  1  channel idle
dma_active  in  1  channel accepting writes
dma_walmostfull  in  1  channel backpressure
dma_wack  in  1  one write acknowledged
dma_start  out  1  start pulse
dma_addr  out  ADDR_W  start address, valid with dma_start
dma_len  out  32  line count, valid with dma_start
dma_we  out  1  write strobe
dma_wdata  out  DATA_W  write data
owner  out  3  current owner index
busy  out  1  channel owned
overrun  out  1  sticky: owner sent lines beyond req_len

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0. All outputs 0 except wr_almostfull = all 1s. Counters cleared. In-flight transfer abandoned; no req_done.
- States: IDLE, START, STREAM, DONE.
- IDLE: scan req_valid from rr_ptr upward with wrap; first set index wins. Latch addr/len/fence; pulse req_grant; owner=win; busy=1.
  - If len==0, go to DONE.
  - Otherwise go to START.
  - No request: remain in IDLE.
- START: wait for dma_idle. Then pulse dma_start with dma_addr/dma_len, clear sent/ack counters, go to STREAM.
- STREAM:
  - wr_almostfull[owner] = dma_walmostfull | !dma_active, registered by one cycle.
  - Non-owners always see wr_almostfull=1.
  - wr_valid[owner] & dma_active & sent<len: dma_we=1, dma_wdata=wr_data[owner] one cycle later; sent++.
  - wr_valid[owner] when sent==len: data dropped, overrun=1 (cleared only by reset).
  - dma_wack: ack++, independent of writes; simultaneous write and ack both count.
  - Exit to DONE when fence=0 and the cycle issuing write number len; or fence=1 and the cycle receiving ack number len.
- DONE: pulse req_done[owner]; rr_ptr=owner+1 mod NUM_REQ; busy=0; go to IDLE. Earliest re-grant is the next cycle.
- A requester dropping req_valid before grant is not granted; the scan repeats.
- Counters are 32-bit; len up to 2^32-1.
- Latency:
  - req_valid to req_grant: 1 cycle.
  - grant to dma_start: ≥1 cycle.
  - wr_valid to dma_we: 1 cycle.

Optional Feature:
GLM_WRARB_TIMEOUT_EN
- Defined:
  - A 20-bit watchdog counts STREAM cycles without a write or ack.
  - At 2^20-1 it forces DONE, pulses req_done[owner], and sets sticky output timeout (extra 1-bit port, reset 0).
- Undefined: no watchdog, no timeout port; STREAM waits indefinitely.

Test Plan:
- req_valid=0001, len=4, fence=0, dma_idle=1 → grant=0001 next cycle, dma_start with len 4, 4 dma_we; req_done[0] in the cycle after the 4th write; rr_ptr=1.
- req_valid=1111 held, len=2 each → grants in order 0,1,2,3,0; no requester granted twice before others.
- fence=1, len=3, acks delayed 10 cycles → req_done only after 3rd dma_wack, not after 3rd write.
- len=0 on requester 2 → grant then req_done 1 cycle later; dma_start never asserted.
- Owner sends 5 lines with len=4 → exactly 4 dma_we, overrun=1; non-owner wr_valid never reaches dma_we.
- reset asserted mid-STREAM → outputs cleared without waiting for a clk edge; busy=0, no req_done; next request arbitrates from index 0.
